pe_result_writeback: RTL and testbench
======================================

Name: pe_result_writeback

Overview:
- Return path of the vector datapath: captures the four 32-bit PE results when the PE array signals completion and writes them back to BRAM.
- Writes are serialized one word per granted cycle to consecutive word addresses starting at a latched base address.
- Shares the BRAM port with the operand fetch unit through a simple grant input.
- Pulses done when the last word is committed.

Parameters:
- NUM_PE, 4, number of PE results captured per completion (1..8)
- DATA_W, 32, result/BRAM data width
- ADDR_W, 32, BRAM byte-address width
- ADDR_STEP, 4, byte increment between consecutive result words

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- donePE  in  1  PE array completion strobe, sampled each cycle
- resPE  in  NUM_PE*DATA_W  packed PE results, PE0 in bits [DATA_W-1:0]
- baseAddr  in  ADDR_W  first write byte address, latched at capture
- bramGnt  in  1  BRAM port granted this cycle; write commits only when high
- bramEn  out  1  write request / BRAM enable
- bramWe  out  DATA_W/8  byte write enables, all ones while bramEn=1, else 0
- bramAddr  out  ADDR_W  write byte address
- bramDin  out  DATA_W  write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the final write commits
- ovf  out  1  sticky: donePE seen while not IDLE

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk.
  - State goes to IDLE, idx=0, ovf=0.
  - Outputs: bramEn=0, bramWe=0, bramAddr=0, bramDin=0, busy=0, done=0.
  - Capture registers are cleared to 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On a clock edge with donePE=1: latch resPE into NUM_PE capture registers, latch baseAddr, idx<=0, state<=WRITE.
  - Otherwise remain in IDLE.
- WRITE:
  - bramEn=1, bramWe=all ones, bramAddr=base+idx*ADDR_STEP (mod 2^ADDR_W), bramDin=cap[idx]. These outputs are decoded from registered state/idx/cap only, with no input-to-output combinational path.
  - A write commits on an edge where bramGnt=1.
  - On commit, if idx<NUM_PE-1 then idx<=idx+1; if idx==NUM_PE-1 then state<=DONE.
  - With bramGnt=0: hold idx, address and data unchanged; the request stays asserted.
- DONE:
  - done=1 and bramEn=0 for exactly one cycle, then state<=IDLE.
  - donePE in this cycle is not captured.
- Latency: donePE sampled at edge E0.
  - With bramGnt held high, words 0..NUM_PE-1 are presented in cycles 1..NUM_PE.
  - done is high in cycle NUM_PE+1; busy is low again in cycle NUM_PE+2.
  - Each cycle of bramGnt=0 during WRITE adds one cycle.
- Overlap: donePE=1 while in WRITE or DONE is ignored (capture registers are unchanged) and sets ovf. ovf is cleared only by reset.
- Address wrap: base+idx*ADDR_STEP wraps modulo 2^ADDR_W with no error.
- Reset mid-WRITE: the next cycle has bramEn=0, no further writes and no done pulse. Words already committed stay in BRAM.
- The capture registers are the only storage of results; resPE may change freely after the capture edge.
- idx width is $clog2(NUM_PE) with a minimum of 1.

Decomposition:
- Shared package vp_pkg holds:
  - state enum wb_state_t {IDLE, WRITE, DONE}
  - localparams NUM_PE_DEF=4, WORD_BYTES=4 (shared with the fetch unit's address stepping)
- A single module; no sub-module is warranted. The capture register file is a generate loop inside it.

Test Plan:
- Basic write:
  - Stimulus: baseAddr=0x100, resPE={0x44,0x33,0x22,0x11} (PE3..PE0), donePE pulsed, bramGnt=1.
  - Required response: writes (0x100,0x11), (0x104,0x22), (0x108,0x33), (0x10C,0x44) in consecutive cycles; done high exactly one cycle, 5 cycles after the capture edge; bramWe=4'hF on every write.
- Grant stall:
  - Stimulus: as basic write, with bramGnt=0 for 2 cycles while word1 is presented.
  - Required response: addr 0x104 / data 0x22 held for 3 cycles; exactly 4 commits; done is delayed by 2 cycles.
- Overlap:
  - Stimulus: a second donePE with resPE=0xDEAD.. arriving during WRITE.
  - Required response: ovf=1 and stays 1; written data remains the first capture; no second write burst follows.
- Input change after capture:
  - Stimulus: resPE changes on the cycle after the capture edge.
  - Required response: BRAM still receives the captured values.
- Address wrap:
  - Stimulus: baseAddr=0xFFFFFFF8.
  - Required response: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset mid-operation:
  - Stimulus: rstn=0 for 1 cycle after word1 commits.
  - Required response: bramEn=0 from the next cycle; no done pulse; ovf=0; busy=0; a subsequent donePE starts a full 4-word write.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared vector-datapath definitions: writeback FSM states and word geometry
// common to the fetch and writeback units.
package vp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wb_state_t;

  localparam int NUM_PE_DEF = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/pe_result_writeback.sv
// Captures PE results on donePE and writes them to BRAM one word per granted cycle;
// first word presented 1 cycle after capture, request held (address/data stable) while bramGnt=0.
module pe_result_writeback
  import vp_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = WORD_BYTES
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     donePE,
  input  logic [NUM_PE*DATA_W-1:0] resPE,
  input  logic [ADDR_W-1:0]        baseAddr,
  input  logic                     bramGnt,
  output logic                     bramEn,
  output logic [DATA_W/8-1:0]      bramWe,
  output logic [ADDR_W-1:0]        bramAddr,
  output logic [DATA_W-1:0]        bramDin,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  wb_state_t          state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [ADDR_W-1:0]  base;
  logic [DATA_W-1:0]  cap [NUM_PE];
  logic               capture;
  logic               ovf_q;
  logic               wr;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (donePE) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (bramGnt) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (capture) begin
        base <= baseAddr;
      end
      // A completion arriving mid-burst is dropped; only the flag records it.
      if (donePE && (state != IDLE)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_cap
    always_ff @(posedge clk) begin
      if (!rstn) begin
        cap[g] <= '0;
      end else if (capture) begin
        cap[g] <= resPE[g*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs decode registered state only, so grant never reaches them combinationally.
  assign wr       = (state == WRITE);
  assign bramEn   = wr;
  assign bramWe   = {(DATA_W/8){wr}};
  assign bramAddr = wr ? (base + ADDR_W'(idx) * ADDR_W'(ADDR_STEP)) : '0;
  assign bramDin  = wr ? cap[idx] : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pe_result_writeback.sv
// Directed bench for pe_result_writeback: burst, stall, overlap, wrap and mid-burst reset.
module tb_pe_result_writeback;

  logic         clk;
  logic         rstn;
  logic         donePE;
  logic [127:0] resPE;
  logic [31:0]  baseAddr;
  logic         bramGnt;
  logic         bramEn;
  logic [3:0]   bramWe;
  logic [31:0]  bramAddr;
  logic [31:0]  bramDin;
  logic         busy;
  logic         done;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int commits = 0;

  pe_result_writeback dut (
    .clk      (clk),
    .rstn     (rstn),
    .donePE   (donePE),
    .resPE    (resPE),
    .baseAddr (baseAddr),
    .bramGnt  (bramGnt),
    .bramEn   (bramEn),
    .bramWe   (bramWe),
    .bramAddr (bramAddr),
    .bramDin  (bramDin),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable around the negedge, so this sees exactly the granted writes.
  always @(negedge clk) begin
    if (rstn && bramEn && bramGnt) commits++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".en"},   64'(bramEn),   64'd1);
    chk({tag, ".we"},   64'(bramWe),   64'hF);
    chk({tag, ".addr"}, 64'(bramAddr), 64'(a));
    chk({tag, ".din"},  64'(bramDin),  64'(d));
    chk({tag, ".done"}, 64'(done),     64'd0);
  endtask

  task automatic start(input logic [31:0] base, input logic [127:0] r);
    donePE   = 1'b1;
    resPE    = r;
    baseAddr = base;
    tick();
    donePE   = 1'b0;
  endtask

  task automatic chk_done_then_idle(input string tag);
    chk({tag, ".done_hi"}, 64'(done),   64'd1);
    chk({tag, ".done_en"}, 64'(bramEn), 64'd0);
    chk({tag, ".done_bz"}, 64'(busy),   64'd1);
    tick();
    chk({tag, ".done_lo"}, 64'(done),   64'd0);
    chk({tag, ".idle_bz"}, 64'(busy),   64'd0);
  endtask

  initial begin
    rstn     = 1'b0;
    donePE   = 1'b0;
    resPE    = '0;
    baseAddr = '0;
    bramGnt  = 1'b1;
    tick();
    tick();
    chk("rst.en",   64'(bramEn),   64'd0);
    chk("rst.we",   64'(bramWe),   64'd0);
    chk("rst.addr", 64'(bramAddr), 64'd0);
    chk("rst.din",  64'(bramDin),  64'd0);
    chk("rst.busy", 64'(busy),     64'd0);
    chk("rst.done", 64'(done),     64'd0);
    chk("rst.ovf",  64'(ovf),      64'd0);
    rstn = 1'b1;
    tick();

    // Basic burst with grant always high
    commits = 0;
    start(32'h100, {32'h44, 32'h33, 32'h22, 32'h11});
    chk_word("basic.w0", 32'h100, 32'h11); tick();
    chk_word("basic.w1", 32'h104, 32'h22); tick();
    chk_word("basic.w2", 32'h108, 32'h33); tick();
    chk_word("basic.w3", 32'h10C, 32'h44); tick();
    chk_done_then_idle("basic");
    chk("basic.commits", 64'(commits), 64'd4);
    chk("basic.ovf",     64'(ovf),     64'd0);

    // Grant withheld for two cycles on word 1
    commits = 0;
    start(32'h100, {32'h44, 32'h33, 32'h22, 32'h11});
    chk_word("stall.w0", 32'h100, 32'h11); tick();
    bramGnt = 1'b0;
    chk_word("stall.w1a", 32'h104, 32'h22); tick();
    chk_word("stall.w1b", 32'h104, 32'h22); tick();
    bramGnt = 1'b1;
    chk_word("stall.w1c", 32'h104, 32'h22); tick();
    chk_word("stall.w2", 32'h108, 32'h33); tick();
    chk_word("stall.w3", 32'h10C, 32'h44); tick();
    chk_done_then_idle("stall");
    chk("stall.commits", 64'(commits), 64'd4);

    // Overlapping donePE, input change after capture, donePE during DONE
    commits = 0;
    start(32'h200, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    resPE = {4{32'hDEADBEEF}};
    chk_word("ovl.w0", 32'h200, 32'hA1); tick();
    donePE = 1'b1;
    chk_word("ovl.w1", 32'h204, 32'hA2); tick();
    donePE = 1'b0;
    chk("ovl.ovf_set", 64'(ovf), 64'd1);
    chk_word("ovl.w2", 32'h208, 32'hA3); tick();
    chk_word("ovl.w3", 32'h20C, 32'hA4); tick();
    donePE = 1'b1;
    chk("ovl.done_hi", 64'(done), 64'd1);
    tick();
    donePE = 1'b0;
    chk("ovl.idle_bz", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ovl.no_burst", 64'(bramEn), 64'd0);
      tick();
    end
    chk("ovl.commits",    64'(commits), 64'd4);
    chk("ovl.ovf_sticky", 64'(ovf),     64'd1);

    // Address wrap at the top of the address space
    start(32'hFFFF_FFF8, {32'h5004, 32'h5003, 32'h5002, 32'h5001});
    chk_word("wrap.w0", 32'hFFFF_FFF8, 32'h5001); tick();
    chk_word("wrap.w1", 32'hFFFF_FFFC, 32'h5002); tick();
    chk_word("wrap.w2", 32'h0000_0000, 32'h5003); tick();
    chk_word("wrap.w3", 32'h0000_0004, 32'h5004); tick();
    chk_done_then_idle("wrap");

    // Reset one cycle after word 1 commits, then a fresh burst
    commits = 0;
    start(32'h300, {32'h64, 32'h63, 32'h62, 32'h61});
    chk_word("rmid.w0", 32'h300, 32'h61); tick();
    chk_word("rmid.w1", 32'h304, 32'h62); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rmid.en",   64'(bramEn),   64'd0);
    chk("rmid.busy", 64'(busy),     64'd0);
    chk("rmid.done", 64'(done),     64'd0);
    chk("rmid.ovf",  64'(ovf),      64'd0);
    chk("rmid.addr", 64'(bramAddr), 64'd0);
    tick();
    chk("rmid.done2", 64'(done),   64'd0);
    chk("rmid.en2",   64'(bramEn), 64'd0);
    start(32'h400, {32'h74, 32'h73, 32'h72, 32'h71});
    chk_word("post.w0", 32'h400, 32'h71); tick();
    chk_word("post.w1", 32'h404, 32'h72); tick();
    chk_word("post.w2", 32'h408, 32'h73); tick();
    chk_word("post.w3", 32'h40C, 32'h74); tick();
    chk_done_then_idle("post");
    chk("post.commits", 64'(commits), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
